// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the 16-bit external SRAM data-memory path.
package arm_mem_pkg;

    localparam int DEFAULT_BASE_ADDR   = 1024;
    localparam int DEFAULT_SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the data-memory port: request, store data, load data and freeze.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two fixed-length 16-bit SRAM phases,
// holding ready low as a pipeline freeze while the sequence runs.
//
//   state | meaning
//   IDLE  | no work; accept and latch a request
//   LOW   | half-word 0 (bits 15:0), ACCESS_CYCLES cycles
//   HIGH  | half-word 1 (bits 31:16), ACCESS_CYCLES cycles
//   DONE  | one cycle, ready high, bus idle
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int          SRAM_ADDR_W   = DEFAULT_SRAM_ADDR_W,
    parameter int          ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       mem,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int IDX_W = SRAM_ADDR_W - 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic              op_wr;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              req;
    logic              phase_last;
    logic              phase_entry;
    logic              ready_c;

    assign req           = mem.rd_en | mem.wr_en;
    assign phase_last    = (cnt == '0);
    assign phase_entry   = (next_state != state) && ((next_state == LOW) || (next_state == HIGH));
    assign mem.read_data = rdata;
    assign mem.ready     = ready_c;

    always_comb begin
        next_state  = state;
        ready_c     = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                ready_c = !req;
                if (req) next_state = LOW;
            end
            LOW: begin
                sram_addr = {word_idx, 1'b0};
                if (op_wr) begin
                    sram_dq_out = wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (phase_last) next_state = HIGH;
            end
            HIGH: begin
                sram_addr = {word_idx, 1'b1};
                if (op_wr) begin
                    sram_dq_out = wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
                if (phase_last) next_state = DONE;
            end
            DONE: begin
                ready_c    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Down-counter reloaded on every phase entry; the phase ends at terminal count zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (phase_entry) begin
            cnt <= CNT_LOAD;
        end else if (!phase_last) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Write wins when both strobes are high; the byte offset within the word is dropped
    // and the word index wraps modulo the SRAM size.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr    <= 1'b0;
            word_idx <= '0;
            wdata    <= '0;
        end else if ((state == IDLE) && req) begin
            op_wr    <= mem.wr_en;
            word_idx <= IDX_W'((mem.address - BASE_ADDR) >> 2);
            wdata    <= mem.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (!op_wr && phase_last) begin
            if (state == LOW)  rdata[15:0]  <= sram_dq_in;
            if (state == HIGH) rdata[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench: two controllers (2-cycle and 1-cycle phases), each on its own
// behavioural SRAM, checked against a word-level memory model and the access timing rules.
module tb_sram_controller;
    import arm_mem_pkg::*;

    typedef struct {
        bit          is_wr;
        logic [31:0] data;
        int          idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_controller_if bus0();
    sram_controller_if bus1();

    logic [17:0] sa0, sa1;
    logic [15:0] sdo0, sdo1, sdi0, sdi1;
    logic        oe0, oe1, we0, we1;

    sram_controller #(.ACCESS_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst_n), .mem(bus0),
        .sram_addr(sa0), .sram_dq_out(sdo0), .sram_dq_in(sdi0),
        .sram_dq_oe(oe0), .sram_we_n(we0)
    );

    sram_controller #(.ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst_n), .mem(bus1),
        .sram_addr(sa1), .sram_dq_out(sdo1), .sram_dq_in(sdi1),
        .sram_dq_oe(oe1), .sram_we_n(we1)
    );

    logic [15:0] sram0 [0:262143];
    logic [15:0] sram1 [0:262143];
    always @(posedge clk) if (!we0) sram0[sa0] = sdo0;
    always @(posedge clk) if (!we1) sram1[sa1] = sdo1;
    assign sdi0 = sram0[sa0];
    assign sdi1 = sram1[sa1];

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] ref0 [int];
    logic [31:0] ref1 [int];
    exp_t q0 [$];
    exp_t q1 [$];

    bit          busy [2];
    int          cyc [2];
    logic [31:0] last_rd [2];
    exp_t        cur [2];
    int          acc [2] = '{2, 1};

    task automatic chk(int d, string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL d%0d %s: got %h expected %h at %0t", d, name, act, exp, $time);
        end
    endtask

    function automatic int word_idx(logic [31:0] addr);
        return int'(((addr - 32'd1024) >> 2) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] ref_read(int d, int idx);
        if (d == 0) return ref0.exists(idx) ? ref0[idx] : 32'h0;
        return ref1.exists(idx) ? ref1[idx] : 32'h0;
    endfunction

    task automatic push_exp(int d, bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        exp_t e;
        e.idx   = word_idx(addr);
        e.is_wr = wr;
        if (wr) begin
            e.data = data;
            if (d == 0) ref0[e.idx] = data; else ref1[e.idx] = data;
        end else begin
            e.data = rd ? ref_read(d, e.idx) : 32'h0;
        end
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drive(int d, bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        if (d == 0) begin
            bus0.rd_en = rd; bus0.wr_en = wr; bus0.address = addr; bus0.write_data = data;
        end else begin
            bus1.rd_en = rd; bus1.wr_en = wr; bus1.address = addr; bus1.write_data = data;
        end
    endtask

    // Called just after a rising edge; holds the request until ready, then drops it
    // just after the following rising edge.
    task automatic issue(int d, bit rd, bit wr, logic [31:0] addr, logic [31:0] data);
        bit got;
        got = 1'b0;
        push_exp(d, rd, wr, addr, data);
        drive(d, rd, wr, addr, data);
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = (d == 0) ? bus0.ready : bus1.ready;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL d%0d ready timeout: got 0 expected 1 within 100 cycles", d);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic mon_step(int d);
        logic        rdy, req, oe, we;
        logic [17:0] sa;
        logic [15:0] sdo;
        logic [31:0] rd;
        int          a, last;
        bit          empty;
        bit          half;
        a = acc[d];
        last = 2 * a + 1;
        if (d == 0) begin
            rdy = bus0.ready; req = bus0.rd_en | bus0.wr_en; rd = bus0.read_data;
            sa = sa0; sdo = sdo0; oe = oe0; we = we0;
        end else begin
            rdy = bus1.ready; req = bus1.rd_en | bus1.wr_en; rd = bus1.read_data;
            sa = sa1; sdo = sdo1; oe = oe1; we = we1;
        end
        if (!busy[d] && req) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk(d, "unexpected request", 32'h1, 32'h0);
                return;
            end
            cur[d]  = (d == 0) ? q0.pop_front() : q1.pop_front();
            busy[d] = 1'b1;
            cyc[d]  = 0;
        end
        if (busy[d]) begin
            chk(d, $sformatf("ready c%0d", cyc[d]), 32'(rdy), 32'(cyc[d] == last));
            if (cyc[d] == 0) begin
                chk(d, "accept addr", 32'(sa), 32'h0);
                chk(d, "accept we_n", 32'(we), 32'h1);
                chk(d, "accept oe", 32'(oe), 32'h0);
                chk(d, "accept dq_out", 32'(sdo), 32'h0);
            end else if (cyc[d] == last) begin
                chk(d, "done we_n", 32'(we), 32'h1);
                chk(d, "done oe", 32'(oe), 32'h0);
                if (cur[d].is_wr) begin
                    chk(d, "sram low half", 32'((d == 0) ? sram0[2*cur[d].idx]   : sram1[2*cur[d].idx]),   32'(cur[d].data[15:0]));
                    chk(d, "sram high half", 32'((d == 0) ? sram0[2*cur[d].idx+1] : sram1[2*cur[d].idx+1]), 32'(cur[d].data[31:16]));
                    chk(d, "read_data held on write", rd, last_rd[d]);
                end else begin
                    chk(d, "read_data", rd, cur[d].data);
                    last_rd[d] = cur[d].data;
                end
                busy[d] = 1'b0;
            end else begin
                half = (cyc[d] > a);
                chk(d, "phase addr", 32'(sa), 32'(2 * cur[d].idx + int'(half)));
                if (cur[d].is_wr) begin
                    chk(d, "write we_n", 32'(we), 32'h0);
                    chk(d, "write oe", 32'(oe), 32'h1);
                    chk(d, "write dq_out", 32'(sdo), half ? 32'(cur[d].data[31:16]) : 32'(cur[d].data[15:0]));
                    chk(d, "read_data held on write", rd, last_rd[d]);
                end else begin
                    chk(d, "read we_n", 32'(we), 32'h1);
                    chk(d, "read oe", 32'(oe), 32'h0);
                end
            end
            cyc[d]++;
        end else begin
            chk(d, "idle ready", 32'(rdy), 32'h1);
            chk(d, "idle we_n", 32'(we), 32'h1);
            chk(d, "idle oe", 32'(oe), 32'h0);
            chk(d, "idle addr", 32'(sa), 32'h0);
            chk(d, "idle read_data", rd, last_rd[d]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            for (int d = 0; d < 2; d++) begin
                busy[d]    = 1'b0;
                last_rd[d] = 32'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) mon_step(d);
        end
    end

    task automatic random_ops(int d, int count);
        logic [31:0] addr;
        int kind;
        for (int i = 0; i < count; i++) begin
            addr = 32'd1024 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            kind = $urandom_range(0, 2);
            issue(d, kind != 1, kind != 0, addr, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 262144; i++) begin
            sram0[i] = 16'h0;
            sram1[i] = 16'h0;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk(0, "reset read_data", bus0.read_data, 32'h0);
        chk(1, "reset read_data", bus1.read_data, 32'h0);
        chk(0, "reset we_n", 32'(we0), 32'h1);
        chk(0, "reset state", 32'(dut0.state), 32'(IDLE));
        rst_n = 1'b1;

        repeat (10) @(posedge clk);
        #1;

        issue(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b0, 32'd1024, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        v = $urandom;
        issue(0, 1'b0, 1'b1, 32'd1044, v);
        issue(0, 1'b1, 1'b0, 32'd1044, 32'h0);
        issue(0, 1'b0, 1'b1, 32'd1020, $urandom);
        issue(0, 1'b1, 1'b0, 32'd1020, 32'h0);
        issue(0, 1'b1, 1'b0, 32'd1024 + 32'h80000 + 32'd21, 32'h0);
        random_ops(0, 40);

        // Abort a read in its upper-half phase.
        push_exp(0, 1'b1, 1'b0, 32'd1044, 32'h0);
        drive(0, 1'b1, 1'b0, 32'd1044, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk(0, "abort read_data", bus0.read_data, 32'h0);
        chk(0, "abort we_n", 32'(we0), 32'h1);
        chk(0, "abort oe", 32'(oe0), 32'h0);
        chk(0, "abort addr", 32'(sa0), 32'h0);
        chk(0, "abort state", 32'(dut0.state), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(0, "post-reset ready", 32'(bus0.ready), 32'h1);
        chk(0, "post-reset state", 32'(dut0.state), 32'(IDLE));
        @(posedge clk);
        #1;
        issue(0, 1'b1, 1'b0, 32'd1044, 32'h0);

        issue(1, 1'b0, 1'b1, 32'd1036, 32'h12345678);
        issue(1, 1'b1, 1'b0, 32'd1036, 32'h0);
        issue(1, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D);
        issue(1, 1'b1, 1'b0, 32'd1040, 32'h0);
        random_ops(1, 30);

        repeat (3) @(posedge clk);
        chk(0, "scoreboard drained", 32'(q0.size()), 32'h0);
        chk(1, "scoreboard drained", 32'(q1.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sits downstream of the MEM stage and replaces its single-cycle data memory with an external 16-bit asynchronous SRAM.
- Converts each 32-bit word read or write into two 16-bit half-word accesses, each lasting a fixed number of cycles.
- Drives `ready` low while busy; the processor uses `ready` as a pipeline freeze.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: width of the SRAM half-word address bus.
- ACCESS_CYCLES, 2: cycles per half-word phase (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request from MEM stage.
- wr_en  in  1  write request from MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (val_rm).
- read_data  out  32  loaded word.
- ready  out  1  1 = no outstanding work or access completing this cycle; 0 = freeze pipeline.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_dq_out  out  16  data driven to SRAM.
- sram_dq_in  in  16  data returned by SRAM.
- sram_dq_oe  out  1  1 = controller drives the data bus.
- sram_we_n  out  1  active-low SRAM write enable.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; counter=0; latched request regs=0; read_data=0.
  - Combinational outputs in IDLE: sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - A reset asserted mid-operation aborts the access. The half already written is not rolled back, and ready does not pulse.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - ready = !(rd_en | wr_en).
  - On a request, latch the operation (wr_en has priority if both are high, treated as a write), address and write_data, then go to LOW.
- LOW:
  - Lasts ACCESS_CYCLES cycles, counted by the counter; counter resets at each phase entry.
  - sram_addr = {word_idx, 1'b0}.
  - Write: sram_dq_out = wdata[15:0], sram_dq_oe=1, sram_we_n=0 for the whole phase.
  - Read: capture sram_dq_in into read_data[15:0] on the last cycle of the phase.
  - Then go to HIGH.
- HIGH:
  - Same as LOW with sram_addr = {word_idx, 1'b1} and the upper half (wdata[31:16] / read_data[31:16]).
  - Then go to DONE.
- DONE: one cycle, ready=1, SRAM bus idle (we_n=1, oe=0); next state is IDLE.
- Address mapping: word_idx = ((address − BASE_ADDR) >> 2) truncated to SRAM_ADDR_W−1 bits.
  - Modulo wrap for out-of-range addresses; no error flag.
  - address[1:0] is ignored.
- Latency: with the request first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..A, HIGH occupies A+1..2A, ready=1 at cycle 2A+1, where A = ACCESS_CYCLES.
- read_data:
  - Updated only by reads.
  - Valid at DONE and held until the next read overwrites it.
  - The low half changes before the high half during a read; consumers sample only when ready=1.
- Request inputs are ignored outside IDLE. The requester holds them stable until ready; the controller uses its latched copies.
- Back-to-back: a request present in the cycle after DONE (state IDLE) is accepted immediately; there are no dead cycles beyond DONE.

Decomposition:
- Shared package arm_mem_pkg:
  - state enum {IDLE, LOW, HIGH, DONE} (2-bit);
  - DEFAULT_BASE_ADDR=1024;
  - SRAM data width 16;
  - default SRAM_ADDR_W.
- The phase counter is inline. The half-word sequencer is simple enough that no sub-module is needed.

Test Plan (ACCESS_CYCLES=2 unless noted; the bench provides a behavioural 16-bit SRAM model):
- Idle, rd_en=wr_en=0 for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0 throughout.
- Write 0xDEADBEEF to 1024 at cycle 0 ->
  - cycles 1–2: sram_addr=0, dq_out=0xBEEF, we_n=0, oe=1;
  - cycles 3–4: sram_addr=1, dq_out=0xDEAD;
  - ready=0 in cycles 0–4, ready=1 in cycle 5;
  - model holds [0]=0xBEEF, [1]=0xDEAD.
- Read 1024 after the previous write -> we_n=1 and oe=0 throughout; read_data=0xDEADBEEF with ready=1 at cycle 5; value is held through 3 idle cycles.
- Write to 1024+4*5 immediately followed by a read of the same address (requests held until ready) -> sram_addr 10, 11 for the write and then 10, 11 for the read; the read is accepted in the cycle after the write's DONE; read_data returns the written word.
- Reset pulse (rst=0) during the HIGH phase of a read -> outputs return immediately to reset values, read_data=0; after release with no request, ready=1 and state is IDLE.
- ACCESS_CYCLES=1, write 0x12345678 to 1024+4*3 -> sram_addr=6 (0x5678) at cycle 1, sram_addr=7 (0x1234) at cycle 2, ready at cycle 3. Also with rd_en=wr_en=1 simultaneously -> treated as a write.
